instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the immediate-extraction path: assembles a 32-bit RV32I instruction word from separate fields (opcode, registers, funct, 32-bit signed immediate).
- Sits between the boot/debug loader or self-test sequencer and the instruction-memory write port.
- Streaming valid/ready on both sides; 1-entry output register plus 1-entry skid buffer.
- Per-word error flag and a running count of emitted words.

Parameters:
- CNT_W, 16: width of the emitted-word counter o_Count.

Ports:
- i_Clk  input  1  clock, all state on rising edge
- i_Rst  input  1  synchronous, active-high reset
- i_Valid  input  1  input fields valid
- o_Ready  output  1  encoder can accept fields this cycle
- i_Format  input  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6/7 illegal
- i_Opcode  input  7  opcode[6:0], passed through
- i_Rd  input  5  destination register
- i_Rs1  input  5  source register 1
- i_Rs2  input  5  source register 2
- i_Funct3  input  3  funct3
- i_Funct7  input  7  funct7 (R only)
- i_Imm  input  32  signed immediate, byte offset for B/J, full value for U
- o_Valid  output  1  o_Instruction valid
- i_Ready  input  1  downstream accepts word
- o_Instruction  output  32  encoded instruction
- o_Err  output  1  word invalid: illegal format or immediate out of range
- o_Count  output  CNT_W  number of words handed off downstream

Behaviour:
- Reset (i_Rst high at clock edge):
  - o_Valid=0, o_Instruction=0, o_Err=0, o_Count=0, skid buffer emptied.
  - o_Ready=0 while i_Rst is high; o_Ready=1 on the first cycle after reset.
  - Reset asserted mid-operation discards all buffered words; no handshake completes in a reset cycle.
- Encoding (combinational from the inputs, registered on acceptance):
  - R: {Funct7, Rs2, Rs1, Funct3, Rd, Opcode}
  - I: {Imm[11:0], Rs1, Funct3, Rd, Opcode}
  - S: {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode}
  - B: {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Opcode}
  - U: {Imm[31:12], Rd, Opcode}
  - J: {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Opcode}
  - Format 6/7: word = 32'h0, err = 1, regardless of the optional feature.
- Handshake:
  - Input accepted when i_Valid && o_Ready.
  - Output handed off when o_Valid && i_Ready.
  - Latency: a word accepted in cycle N appears on o_Instruction in cycle N+1 if the output register was empty or draining.
  - o_Ready is a registered signal and does not depend combinationally on i_Ready.
- Buffer state machine:
  - EMPTY: out register invalid. Accept -> ONE.
  - ONE, accept and hand-off together: out register reloads, stay ONE.
  - ONE, hand-off only -> EMPTY.
  - ONE, accept only: word goes to skid -> FULL.
  - FULL: o_Ready=0. On hand-off, skid moves to out register -> ONE.
  - Order is strictly preserved. A word and its err flag travel together.
  - o_Instruction and o_Err hold stable while o_Valid && !i_Ready.
- Counter: o_Count increments by 1 on each output handshake and wraps modulo 2^CNT_W (all ones + 1 = 0).

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined: err is set for any of
  - I/S immediate outside [-2048, 2047]
  - B outside [-4096, 4094] or Imm[0]=1
  - J outside [-1048576, 1048574] or Imm[0]=1
  - U with Imm[11:0] != 0
  - The word is still encoded from the truncated bits; R ignores i_Imm.
- Undefined: immediates are silently truncated; o_Err is set only for formats 6/7.

Test Plan:
- R, Funct7=0x20, Rs2=3, Rs1=2, Funct3=0, Rd=1, Opcode=0x33 -> o_Instruction=0x403100B3, o_Err=0, one cycle after acceptance.
- I, Imm=-4, Rs1=2, Funct3=2, Rd=5, Opcode=0x03 -> 0xFFC12283, o_Err=0.
- B, Imm=8, Rs2=2, Rs1=1, Funct3=0, Opcode=0x63 -> 0x00208463.
- I, Imm=2048:
  - With macro: o_Err=1, word imm field 0x800.
  - Without macro: o_Err=0, same word.
  - Format=7 in both builds: word 0x0, o_Err=1.
- Back-pressure: i_Ready=0, three back-to-back valid inputs -> first two accepted, o_Ready=0 from the cycle after the second. Raise i_Ready -> three words out in order, o_Count=3.
- Reset in FULL state with i_Ready=0 -> next cycle o_Valid=0, o_Count=0, o_Ready=0 during reset, 1 after. Count wrap with CNT_W=2: 5 hand-offs -> o_Count=1.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction word assembler with a valid/ready stream, an output register and a skid buffer.
// Optional immediate range checking is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [2:0]       i_Format,
  input  logic [6:0]       i_Opcode,
  input  logic [4:0]       i_Rd,
  input  logic [4:0]       i_Rs1,
  input  logic [4:0]       i_Rs2,
  input  logic [2:0]       i_Funct3,
  input  logic [6:0]       i_Funct7,
  input  logic [31:0]      i_Imm,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [31:0]      o_Instruction,
  output logic             o_Err,
  output logic [CNT_W-1:0] o_Count
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_e;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [31:0]      out_word_q, out_word_d;
  logic             out_err_q, out_err_d;
  logic [31:0]      skid_word_q, skid_word_d;
  logic             skid_err_q, skid_err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      enc_word;
  logic             enc_err;
  logic             accept;
  logic             handoff;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = i_Imm;
`else
  logic unused_imm0;
  assign unused_imm0 = i_Imm[0];
`endif

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (i_Format)
      3'd0: enc_word = {i_Funct7, i_Rs2, i_Rs1, i_Funct3, i_Rd, i_Opcode};
      3'd1: enc_word = {i_Imm[11:0], i_Rs1, i_Funct3, i_Rd, i_Opcode};
      3'd2: enc_word = {i_Imm[11:5], i_Rs2, i_Rs1, i_Funct3, i_Imm[4:0], i_Opcode};
      3'd3: enc_word = {i_Imm[12], i_Imm[10:5], i_Rs2, i_Rs1, i_Funct3,
                        i_Imm[4:1], i_Imm[11], i_Opcode};
      3'd4: enc_word = {i_Imm[31:12], i_Rd, i_Opcode};
      3'd5: enc_word = {i_Imm[20], i_Imm[10:1], i_Imm[11], i_Imm[19:12], i_Rd, i_Opcode};
      default: begin
        enc_word = '0;
        enc_err  = 1'b1;
      end
    endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
    // The word is still built from the truncated bits; only the flag reports the overflow.
    case (i_Format)
      3'd1, 3'd2: if (imm_s < -32'sd2048 || imm_s > 32'sd2047) enc_err = 1'b1;
      3'd3: if (imm_s < -32'sd4096 || imm_s > 32'sd4094 || i_Imm[0]) enc_err = 1'b1;
      3'd4: if (i_Imm[11:0] != 12'h000) enc_err = 1'b1;
      3'd5: if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574 || i_Imm[0]) enc_err = 1'b1;
      default: ;
    endcase
`endif
  end

  assign accept  = i_Valid && ready_q;
  assign handoff = valid_q && i_Ready;

  always_comb begin
    state_d     = state_q;
    out_word_d  = out_word_q;
    out_err_d   = out_err_q;
    skid_word_d = skid_word_q;
    skid_err_d  = skid_err_q;
    count_d     = count_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_word_d = enc_word;
          out_err_d  = enc_err;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && handoff) begin
          out_word_d = enc_word;
          out_err_d  = enc_err;
        end else if (handoff) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          skid_word_d = enc_word;
          skid_err_d  = enc_err;
          state_d     = ST_FULL;
        end
      end
      ST_FULL: begin
        if (handoff) begin
          out_word_d = skid_word_q;
          out_err_d  = skid_err_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (handoff) count_d = count_q + CNT_W'(1);
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= ST_EMPTY;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      out_word_q  <= '0;
      out_err_q   <= 1'b0;
      skid_word_q <= '0;
      skid_err_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      out_word_q  <= out_word_d;
      out_err_q   <= out_err_d;
      skid_word_q <= skid_word_d;
      skid_err_q  <= skid_err_d;
      count_q     <= count_d;
    end
  end

  // ready_q is primed to 1 during reset so it is valid the first cycle after; mask it while reset is held.
  assign o_Ready       = ready_q && !i_Rst;
  assign o_Valid       = valid_q;
  assign o_Instruction = out_word_q;
  assign o_Err         = out_err_q;
  assign o_Count       = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a 2-deep FIFO reference model plus directed literal checks.
// Honours INSTR_ENC_RANGE_CHECK_EN the same way the design does.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_Valid = 1'b0;
  logic        i_Ready = 1'b0;
  logic [2:0]  i_Format = '0;
  logic [6:0]  i_Opcode = '0;
  logic [4:0]  i_Rd = '0, i_Rs1 = '0, i_Rs2 = '0;
  logic [2:0]  i_Funct3 = '0;
  logic [6:0]  i_Funct7 = '0;
  logic [31:0] i_Imm = '0;

  logic        o_Ready, o_Valid, o_Err;
  logic [31:0] o_Instruction;
  logic [15:0] o_Count;
  logic        o_Ready2, o_Valid2, o_Err2;
  logic [31:0] o_Instruction2;
  logic [1:0]  o_Count2;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  bit [32:0]   mq[$];
  int unsigned mcnt = 0;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(16)) u_dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Format(i_Format), .i_Opcode(i_Opcode), .i_Rd(i_Rd), .i_Rs1(i_Rs1),
    .i_Rs2(i_Rs2), .i_Funct3(i_Funct3), .i_Funct7(i_Funct7), .i_Imm(i_Imm),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Instruction(o_Instruction),
    .o_Err(o_Err), .o_Count(o_Count)
  );

  instr_encoder #(.CNT_W(2)) u_dut2 (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .o_Ready(o_Ready2),
    .i_Format(i_Format), .i_Opcode(i_Opcode), .i_Rd(i_Rd), .i_Rs1(i_Rs1),
    .i_Rs2(i_Rs2), .i_Funct3(i_Funct3), .i_Funct7(i_Funct7), .i_Imm(i_Imm),
    .o_Valid(o_Valid2), .i_Ready(i_Ready), .o_Instruction(o_Instruction2),
    .o_Err(o_Err2), .o_Count(o_Count2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding: field placement written as shifts and masks of the immediate value.
  function automatic bit [32:0] model_enc(input bit [2:0] fmt, input bit [6:0] op,
      input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
      input bit [2:0] f3, input bit [6:0] f7, input bit [31:0] imm);
    bit [31:0] w;
    bit [31:0] regs;
    bit        e;
    int        s;
    s    = int'(imm);
    e    = 1'b0;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    case (fmt)
      3'd0: w = (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'(op);
      3'd1: w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
      3'd2: w = (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | 32'(op);
      3'd3: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs |
                (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
      3'd4: w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      3'd5: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                (32'(rd) << 7) | 32'(op);
      default: begin w = 32'h0; e = 1'b1; end
    endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
    if ((fmt == 3'd1 || fmt == 3'd2) && (s < -2048 || s > 2047)) e = 1'b1;
    if (fmt == 3'd3 && (s < -4096 || s > 4094 || (imm % 2) != 0)) e = 1'b1;
    if (fmt == 3'd5 && (s < -1048576 || s > 1048574 || (imm % 2) != 0)) e = 1'b1;
    if (fmt == 3'd4 && (imm % 4096) != 0) e = 1'b1;
`endif
    return {e, w};
  endfunction

  // Reference behaviour: a 2-entry FIFO; ready when fewer than two words are held.
  always @(posedge clk) begin
    bit acc;
    bit hand;
    if (i_Rst) begin
      mq.delete();
      mcnt    = 0;
      started = 1'b1;
    end else begin
      acc  = i_Valid && (mq.size() < 2);
      hand = (mq.size() > 0) && i_Ready;
      if (hand) begin
        void'(mq.pop_front());
        mcnt++;
      end
      if (acc) mq.push_back(model_enc(i_Format, i_Opcode, i_Rd, i_Rs1, i_Rs2,
                                      i_Funct3, i_Funct7, i_Imm));
    end
  end

  always @(negedge clk) begin
    bit [32:0] head;
    if (started) begin
      chk("ready", 64'(o_Ready), 64'(!i_Rst && mq.size() < 2));
      chk("valid", 64'(o_Valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        head = mq[0];
        chk("word", 64'(o_Instruction), 64'(head[31:0]));
        chk("err", 64'(o_Err), 64'(head[32]));
      end
      chk("count", 64'(o_Count), 64'(mcnt % 65536));
      chk("count_w2", 64'(o_Count2), 64'(mcnt % 4));
      chk("valid_w2", 64'(o_Valid2), 64'(o_Valid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input bit [2:0] fmt, input bit [6:0] op, input bit [4:0] rd,
      input bit [4:0] rs1, input bit [4:0] rs2, input bit [2:0] f3, input bit [6:0] f7,
      input bit [31:0] imm);
    i_Format = fmt; i_Opcode = op; i_Rd = rd; i_Rs1 = rs1; i_Rs2 = rs2;
    i_Funct3 = f3; i_Funct7 = f7; i_Imm = imm;
  endtask

  // Present one word for a single cycle into an empty encoder, then check it one cycle later.
  task automatic send_check(input string name, input bit [2:0] fmt, input bit [6:0] op,
      input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2, input bit [2:0] f3,
      input bit [6:0] f7, input bit [31:0] imm, input bit [31:0] exp_w, input bit exp_e);
    set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm);
    i_Valid = 1'b1;
    tick();
    i_Valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 64'(o_Valid), 64'd1);
    chk({name, "_word"}, 64'(o_Instruction), 64'(exp_w));
    chk({name, "_err"}, 64'(o_Err), 64'(exp_e));
    tick();
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    i_Valid = 1'b0;
    tick();
    i_Rst = 1'b0;
  endtask

  initial begin
    bit exp_e2048;
    bit done;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    exp_e2048 = 1'b1;
`else
    exp_e2048 = 1'b0;
`endif
    tick();
    do_reset();
    @(negedge clk);
    chk("rst_valid", 64'(o_Valid), 64'd0);
    chk("rst_word", 64'(o_Instruction), 64'd0);
    chk("rst_err", 64'(o_Err), 64'd0);
    chk("rst_count", 64'(o_Count), 64'd0);
    chk("rst_ready", 64'(o_Ready), 64'd1);
    tick();

    i_Ready = 1'b1;
    send_check("r_type", 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 32'h403100B3, 1'b0);
    send_check("i_neg4", 3'd1, 7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFC, 32'hFFC12283, 1'b0);
    send_check("b_8", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8, 32'h00208463, 1'b0);
    send_check("i_2048", 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'h80000013, exp_e2048);
    send_check("fmt7", 3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0, 32'h00000000, 1'b1);

    // Back-pressure: three back-to-back words with downstream stalled.
    do_reset();
    i_Ready = 1'b0;
    i_Valid = 1'b1;
    set_fields(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
    tick();
    set_fields(3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCDE000);
    tick();
    set_fields(3'd5, 7'h6F, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000100);
    @(negedge clk);
    chk("bp_ready_low", 64'(o_Ready), 64'd0);
    tick();
    tick();
    i_Ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      done = o_Ready;
      tick();
    end
    i_Valid = 1'b0;
    if (!done) chk("bp_accept_timeout", 64'd0, 64'd1);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      done = (o_Count == 16'd3) && !o_Valid;
      if (!done) tick();
    end
    chk("bp_count3", 64'(o_Count), 64'd3);

    // Reset while full and stalled discards everything.
    tick();
    i_Ready = 1'b0;
    i_Valid = 1'b1;
    tick();
    tick();
    i_Valid = 1'b0;
    i_Rst = 1'b1;
    @(negedge clk);
    chk("rst_full_ready", 64'(o_Ready), 64'd0);
    tick();
    i_Rst = 1'b0;
    @(negedge clk);
    chk("rst_full_valid", 64'(o_Valid), 64'd0);
    chk("rst_full_count", 64'(o_Count), 64'd0);
    chk("rst_full_ready1", 64'(o_Ready), 64'd1);
    tick();

    // Five hand-offs: 2-bit counter must wrap to 1.
    i_Ready = 1'b1;
    i_Valid = 1'b1;
    repeat (5) tick();
    i_Valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      done = (o_Count == 16'd5);
      if (!done) tick();
    end
    chk("wrap_count16", 64'(o_Count), 64'd5);
    chk("wrap_count2", 64'(o_Count2), 64'd1);
    tick();

    for (int c = 0; c < 3000; c++) begin
      i_Rst   = ($urandom_range(0, 255) == 0);
      i_Valid = ($urandom_range(0, 3) != 0);
      i_Ready = ($urandom_range(0, 9) < 7);
      i_Format = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      i_Opcode = 7'($urandom); i_Rd = 5'($urandom); i_Rs1 = 5'($urandom);
      i_Rs2 = 5'($urandom); i_Funct3 = 3'($urandom); i_Funct7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: i_Imm = $urandom;
        1: i_Imm = 32'($signed($urandom_range(0, 12287)) - 6144);
        2: i_Imm = $urandom & 32'hFFFFF000;
        default: i_Imm = 32'($signed($urandom_range(0, 4194303)) - 2097152) & 32'hFFFFFFFE;
      endcase
      tick();
    end
    i_Rst = 1'b0;
    i_Valid = 1'b0;
    i_Ready = 1'b1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
